// File: rtl/scalar_wb_arbiter.sv
// Round-robin writeback arbiter driving the scalar register file's single write port, plus a per-register busy scoreboard.
// Latency: grant is combinational; the write appears on regWrEn/regToWrite/dataIn one edge after the handshake.
// Backpressure: at most one reqReady per cycle; ungranted requesters hold their request; the arbiter does not buffer.
module scalar_wb_arbiter #(
    parameter int registerSize      = 32,
    parameter int registerQuantity  = 4,
    parameter int selectionBits     = 2,
    parameter int requesterQuantity = 2,
    parameter int requesterBits     = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [requesterQuantity-1:0]              reqValid,
    input  logic [requesterQuantity*selectionBits-1:0] reqReg,
    input  logic [requesterQuantity*registerSize-1:0]  reqData,
    output logic [requesterQuantity-1:0]              reqReady,
    output logic                                      regWrEn,
    output logic [selectionBits-1:0]                  regToWrite,
    output logic [registerSize-1:0]                   dataIn,
    input  logic                                      reserveEn,
    input  logic [selectionBits-1:0]                  reserveReg,
    output logic [registerQuantity-1:0]               busy
);

    localparam logic [requesterBits-1:0] LAST_REQ = requesterBits'(requesterQuantity - 1);

    logic [requesterBits-1:0]    ptr;
    logic [requesterBits-1:0]    ptr_nxt;
    logic [requesterBits-1:0]    grant_idx;
    logic                        grant_vld;
    logic [selectionBits-1:0]    grant_reg;
    logic [registerSize-1:0]     grant_data;
    logic [registerQuantity-1:0] busy_nxt;
    int                          cand;

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_reg  = '0;
        grant_data = '0;
        cand       = 0;
        for (int j = 0; j < requesterQuantity; j++) begin
            cand = (int'(ptr) + j) % requesterQuantity;
            if (!grant_vld && reqValid[cand]) begin
                grant_vld  = 1'b1;
                grant_idx  = requesterBits'(cand);
                grant_reg  = reqReg[cand*selectionBits +: selectionBits];
                grant_data = reqData[cand*registerSize +: registerSize];
            end
        end
        if (!reset) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        reqReady = '0;
        for (int i = 0; i < requesterQuantity; i++) begin
            reqReady[i] = grant_vld && (grant_idx == requesterBits'(i));
        end
    end

    assign ptr_nxt = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;

    // A new reservation beats a same-cycle clear of the same register.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < registerQuantity; k++) begin
            if (reserveEn && (reserveReg == selectionBits'(k))) begin
                busy_nxt[k] = 1'b1;
            end else if (regWrEn && (regToWrite == selectionBits'(k))) begin
                busy_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrEn    <= 1'b0;
            regToWrite <= '0;
            dataIn     <= '0;
            ptr        <= '0;
            busy       <= '0;
        end else begin
            regWrEn <= grant_vld;
            busy    <= busy_nxt;
            if (grant_vld) begin
                regToWrite <= grant_reg;
                dataIn     <= grant_data;
                ptr        <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed scenarios plus random traffic checked against a behavioural model.
module tb_scalar_wb_arbiter;
    localparam int RS  = 32;
    localparam int RQN = 4;
    localparam int SB  = 2;
    localparam int NQ  = 2;
    localparam int NB  = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ-1:0]     reqValid;
    logic [NQ*SB-1:0]  reqReg;
    logic [NQ*RS-1:0]  reqData;
    logic [NQ-1:0]     reqReady;
    logic              regWrEn;
    logic [SB-1:0]     regToWrite;
    logic [RS-1:0]     dataIn;
    logic              reserveEn;
    logic [SB-1:0]     reserveReg;
    logic [RQN-1:0]    busy;

    scalar_wb_arbiter #(
        .registerSize(RS), .registerQuantity(RQN), .selectionBits(SB),
        .requesterQuantity(NQ), .requesterBits(NB)
    ) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReg(reqReg), .reqData(reqData),
        .reqReady(reqReady), .regWrEn(regWrEn), .regToWrite(regToWrite), .dataIn(dataIn),
        .reserveEn(reserveEn), .reserveReg(reserveReg), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: pending requests, pointer, expected write port and scoreboard.
    bit          p_vld [NQ];
    int          p_reg [NQ];
    logic [31:0] p_data[NQ];
    int          m_ptr;
    bit          m_wr;
    int          m_reg;
    logic [31:0] m_data;
    logic [3:0]  m_busy;
    bit          r_en;
    int          r_reg;

    task automatic model_reset();
        m_ptr  = 0;
        m_wr   = 0;
        m_reg  = 0;
        m_data = '0;
        m_busy = '0;
    endtask

    function automatic int model_grant();
        for (int j = 0; j < NQ; j++) begin
            if (p_vld[(m_ptr + j) % NQ]) return (m_ptr + j) % NQ;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NQ; i++) begin
            reqValid[i]           = p_vld[i];
            reqReg[i*SB +: SB]    = SB'(p_reg[i]);
            reqData[i*RS +: RS]   = p_data[i];
        end
        reserveEn  = r_en;
        reserveReg = SB'(r_reg);
    endtask

    task automatic post(input int i, input int rg, input logic [31:0] d);
        p_vld[i]  = 1;
        p_reg[i]  = rg;
        p_data[i] = d;
    endtask

    // One clock: check grant before the edge, advance model at the edge, check registered outputs after.
    task automatic step();
        int            g;
        logic [NQ-1:0] exp_rdy;
        drive();
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("reqReady", 64'(reqReady), 64'(exp_rdy));
        @(posedge clk);
        for (int k = 0; k < RQN; k++) begin
            if (r_en && r_reg == k) m_busy[k] = 1'b1;
            else if (m_wr && m_reg == k) m_busy[k] = 1'b0;
        end
        if (g >= 0) begin
            m_wr     = 1;
            m_reg    = p_reg[g];
            m_data   = p_data[g];
            m_ptr    = (g + 1) % NQ;
            p_vld[g] = 0;
        end else begin
            m_wr = 0;
        end
        #1;
        check("regWrEn", 64'(regWrEn), 64'(m_wr));
        check("regToWrite", 64'(regToWrite), 64'(m_reg));
        check("dataIn", 64'(dataIn), 64'(m_data));
        check("busy", 64'(busy), 64'(m_busy));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        r_en  = 0;
        r_reg = 0;
        for (int i = 0; i < NQ; i++) p_vld[i] = 0;
        model_reset();
        post(0, 1, 32'h1111_0000);
        post(1, 2, 32'h2222_0000);
        drive();
        #12;
        check("rst_reqReady", 64'(reqReady), 64'd0);
        check("rst_regWrEn", 64'(regWrEn), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dataIn", 64'(dataIn), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();                                  // requester 0 first after reset
        step();                                  // then requester 1

        // Single request from requester 1, then an idle cycle
        post(1, 2, 32'hDEADBEEF);
        step();
        check("single_data", 64'(dataIn), 64'hDEADBEEF);
        step();
        check("single_idle_wr", 64'(regWrEn), 64'd0);

        // Both requesters continuously valid: alternate with no bubble
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NQ; i++)
                if (!p_vld[i]) post(i, c % RQN, $urandom);
            step();
            check("rr_no_bubble", 64'(regWrEn), 64'd1);
        end
        for (int i = 0; i < NQ; i++) p_vld[i] = 0;
        step();

        // Reserve r3, then requester 0 writes r3
        r_en = 1; r_reg = 3;
        step();
        r_en = 0;
        check("sb_set", 64'(busy), 64'b1000);
        post(0, 3, 32'hCAFE_0003);
        step();
        check("sb_held_during_write", 64'(busy[3]), 64'd1);
        step();
        check("sb_cleared", 64'(busy[3]), 64'd0);

        // Reserve r1 in the same cycle its write is on the port
        post(0, 1, 32'hCAFE_0001);
        r_en = 1; r_reg = 1;
        step();
        step();
        check("sb_set_wins", 64'(busy[1]), 64'd1);
        r_en = 0;
        step();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NQ; i++)
                if (!p_vld[i] && ($urandom % 3 != 0)) post(i, $urandom_range(0, RQN - 1), $urandom);
            r_en  = ($urandom % 4 == 0);
            r_reg = $urandom_range(0, RQN - 1);
            step();
        end

        // Async reset while a write is on the port
        p_vld[1] = 0;
        post(0, 2, 32'hA5A5_5A5A);
        r_en = 1; r_reg = 2;
        step();
        r_en = 0;
        check("pre_rst_wr", 64'(regWrEn), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_regWrEn", 64'(regWrEn), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_dataIn", 64'(dataIn), 64'd0);
        check("arst_reqReady", 64'(reqReady), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        post(0, 0, 32'h0000_00AA);
        post(1, 1, 32'h0000_00BB);
        step();
        check("post_rst_grant0", 64'(dataIn), 64'hAA);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
